// File: rtl/secure_serdes_decryptor_core.sv
// secure_serdes_decryptor_core: serial ciphertext in, XOR-decrypted byte out.
// Define SERDES_KEY_ROTATE_EN to walk the 16 key bytes, one per frame.
module secure_serdes_decryptor_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         cipher_in,
  output logic [7:0]   plain_byte,
  output logic         plain_valid,
  input  logic         plain_ready,
  output logic         busy,
  output logic         done,
  output logic         overflow
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DECRYPT
  } state_t;

  state_t     state;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic [7:0] key_byte;
  logic [7:0] result;
  logic       slot_free;

`ifdef SERDES_KEY_ROTATE_EN
  logic [3:0] frame_cnt;
  assign key_byte = key[{frame_cnt, 3'b000} +: 8];
`else
  logic key_unused;
  assign key_unused = ^key[127:8];
  assign key_byte   = key[7:0];
`endif

  assign result    = shift ^ key_byte;
  assign slot_free = !plain_valid || plain_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shift       <= 8'h00;
      bit_cnt     <= 3'd0;
      plain_byte  <= 8'h00;
      plain_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
`ifdef SERDES_KEY_ROTATE_EN
      frame_cnt   <= 4'd0;
`endif
    end else begin
      done <= 1'b0;
      if (plain_valid && plain_ready)
        plain_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RECV;
            bit_cnt <= 3'd0;
            busy    <= 1'b1;
          end
        end
        RECV: begin
          shift   <= {shift[6:0], cipher_in};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state <= DECRYPT;
        end
        DECRYPT: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
`ifdef SERDES_KEY_ROTATE_EN
          frame_cnt <= frame_cnt + 4'd1;
`endif
          // a store in the same cycle as a handshake wins
          if (slot_free) begin
            plain_byte  <= result;
            plain_valid <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secure_serdes_decryptor_core.sv
// tb_secure_serdes_decryptor_core: random and directed frames against
// a frame-level reference model of the output register and key schedule.
module tb_secure_serdes_decryptor_core;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         cipher_in;
  logic [7:0]   plain_byte;
  logic         plain_valid;
  logic         plain_ready;
  logic         busy;
  logic         done;
  logic         overflow;

  int errors;
  int checks;

  logic       exp_valid;
  logic [7:0] exp_byte;
  logic       exp_ovf;
  int         mf;

  secure_serdes_decryptor_core dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .key         (key),
    .cipher_in   (cipher_in),
    .plain_byte  (plain_byte),
    .plain_valid (plain_valid),
    .plain_ready (plain_ready),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one edge where only the consumer handshake can change the register
  task automatic step_m();
    if (exp_valid && plain_ready)
      exp_valid = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b1;
    plain_ready = 1'b1;
    cipher_in = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    exp_valid = 1'b0;
    exp_byte = 8'h00;
    exp_ovf = 1'b0;
    mf = 0;
  endtask

  function automatic logic [7:0] key_byte_of(input int f);
    logic [7:0] kb;
`ifdef SERDES_KEY_ROTATE_EN
    kb = key[8*(f%16) +: 8];
`else
    kb = key[7:0];
    if (f < 0) kb = 8'h00;
`endif
    return kb;
  endfunction

  // start cycle is cycle 0; returns with the bench in cycle 10
  task automatic run_frame(input logic [7:0] c, input logic rdy,
                           input logic poke, input string nm);
    int dc;
    int bz;
    logic [7:0] res;
    dc = 0;
    bz = 0;
    start = 1'b1;
    plain_ready = rdy;
    cipher_in = 1'($urandom);
    step_m();
    start = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      cipher_in = c[i];
      if (poke) start = 1'($urandom);
      if (done) dc++;
      if (!busy) bz++;
      step_m();
    end
    start = poke;
    cipher_in = 1'($urandom);
    if (done) dc++;
    if (!busy) bz++;
    res = c ^ key_byte_of(mf);
    if (!exp_valid || plain_ready) begin
      exp_valid = 1'b1;
      exp_byte = res;
    end else begin
      exp_ovf = 1'b1;
    end
    mf++;
    step();
    start = 1'b0;
    checks++;
    if (dc !== 0) begin
      errors++;
      $display("FAIL %s early_done: got %0d pulses, want 0", nm, dc);
    end
    checks++;
    if (bz !== 0) begin
      errors++;
      $display("FAIL %s busy_low: got %0d idle cycles, want 0", nm, bz);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_c10: got done=%b busy=%b, want 1 0", nm, done, busy);
    end
    checks++;
    if (plain_valid !== exp_valid || plain_byte !== exp_byte) begin
      errors++;
      $display("FAIL %s out: got v=%b b=%h, want v=%b b=%h",
               nm, plain_valid, plain_byte, exp_valid, exp_byte);
    end
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL %s overflow: got %b, want %b", nm, overflow, exp_ovf);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (plain_valid !== 1'b0 || plain_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: got v=%b b=%h, want 0 00", plain_valid, plain_byte);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got d=%b b=%b o=%b, want 0 0 0",
               done, busy, overflow);
    end
  endtask

  task automatic test_basic();
    do_reset();
    key = {$urandom, $urandom, $urandom, 24'($urandom), 8'h5A};
    run_frame(8'hF0, 1'b1, 1'b0, "basic");
    checks++;
    if (plain_byte !== 8'hAA || plain_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_aa: got v=%b b=%h, want 1 aa", plain_valid, plain_byte);
    end
    step_m();
    checks++;
    if (plain_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: got v=%b d=%b, want 0 0", plain_valid, done);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    do_reset();
    key[7:0] = 8'h5A;
    run_frame(8'hF0, 1'b0, 1'b0, "bp");
    for (int i = 0; i < 20; i++) begin
      step_m();
      if (plain_valid !== 1'b1 || plain_byte !== 8'hAA) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable cycles, want 0", bad);
    end
    plain_ready = 1'b1;
    step_m();
    checks++;
    if (plain_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got v=%b, want 0", plain_valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    key[7:0] = 8'h5A;
    run_frame(8'hF0, 1'b0, 1'b0, "ovf1");
    run_frame(8'h0F, 1'b0, 1'b0, "ovf2");
    checks++;
    if (plain_byte !== 8'hAA || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_keep: got b=%h o=%b, want aa 1", plain_byte, overflow);
    end
    plain_ready = 1'b1;
    step_m();
    step_m();
    checks++;
    if (overflow !== 1'b1 || plain_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_sticky: got o=%b v=%b, want 1 0", overflow, plain_valid);
    end
  endtask

  task automatic test_reset_midframe();
    int dc;
    dc = 0;
    do_reset();
    key[7:0] = 8'h5A;
    start = 1'b1;
    plain_ready = 1'b1;
    step_m();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cipher_in = 1'($urandom);
      if (done) dc++;
      step_m();
    end
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    exp_valid = 1'b0;
    exp_byte = 8'h00;
    exp_ovf = 1'b0;
    mf = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dc++;
      step_m();
    end
    checks++;
    if (dc !== 0 || plain_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst: got done=%0d v=%b busy=%b, want 0 0 0",
               dc, plain_valid, busy);
    end
    run_frame(8'h5A, 1'b0, 1'b0, "midrst_frame");
    checks++;
    if (plain_byte !== 8'h00 || plain_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_zero: got v=%b b=%h, want 1 00", plain_valid, plain_byte);
    end
  endtask

  task automatic test_start_in_recv();
    do_reset();
    key = {$urandom, $urandom, $urandom, $urandom};
    run_frame(8'hC3, 1'b0, 1'b1, "restart");
    step_m();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_once: got d=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_key_select();
    do_reset();
    key = {$urandom, $urandom, $urandom, 16'($urandom), 8'h33, 8'h5A};
    run_frame(8'($urandom), 1'b1, 1'b0, "ks1");
    run_frame(8'h33, 1'b1, 1'b0, "ks2");
    checks++;
`ifdef SERDES_KEY_ROTATE_EN
    if (plain_byte !== 8'h00) begin
      errors++;
      $display("FAIL key_rot: got %h, want 00", plain_byte);
    end
`else
    if (plain_byte !== 8'h69) begin
      errors++;
      $display("FAIL key_fixed: got %h, want 69", plain_byte);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int gap;
    int bad;
    bad = 0;
    do_reset();
    key = {$urandom, $urandom, $urandom, $urandom};
    for (int n = 0; n < 40; n++) begin
      run_frame(8'($urandom), 1'($urandom), 1'($urandom), "rand");
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        plain_ready = 1'($urandom);
        start = 1'b0;
        step_m();
        if (plain_valid !== exp_valid || plain_byte !== exp_byte) bad++;
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rand_gap: got %0d bad gap cycles, want 0", bad);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    start = 1'b0;
    key = '0;
    cipher_in = 1'b0;
    plain_ready = 1'b0;
    exp_valid = 1'b0;
    exp_byte = 8'h00;
    exp_ovf = 1'b0;
    mf = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_reset_midframe();
    test_start_in_recv();
    test_key_select();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
